// File: rtl/mouse_cursor_overlay_pkg.sv
// Shared definitions for the mouse cursor overlay stage.
// Holds the cursor bitmap geometry, the ROM row-index width, the "no row"
// index that the bitmap ROM sees outside the cursor, the default sync
// polarity, and the pixel bundle carried down the two-stage pipeline.
package mouse_cursor_overlay_pkg;

    // Default sync polarity: 1 means hsync/vsync are active-low.
    localparam bit SYNC_ACTIVE_LOW_DEF = 1'b1;

    // Cursor bitmap geometry: 8 columns wide, rows 0..10.
    localparam int CURSOR_W_DEF = 8;
    localparam int CURSOR_H_DEF = 11;

    // Width of the row index sent to the bitmap ROM.
    localparam int LINE_W = 5;

    // Row index driven when the pixel is outside the cursor box.
    localparam logic [LINE_W-1:0] NO_LINE = 5'd31;

    // Colour width carried by the pixel bundle.
    localparam int PIX_RGB_W = 12;

    // One pixel as it travels through the pipeline.
    typedef struct packed {
        logic [PIX_RGB_W-1:0] rgb;
        logic                 video_on;
        logic                 hsync;
        logic                 vsync;
    } pixel_t;

endpackage

// File: rtl/mouse_cursor_overlay_cursor_pos_buffer.sv
// Double-buffered cursor position.
// New mouse positions are clamped into the visible area and held as a
// pending value; the pending value is copied into the live position only
// at the start of a frame, so the cursor never moves mid-frame.
//
// Ports:
//   clk, rst_n    pixel clock, asynchronous active-low reset
//   i_vsync       raw vertical sync from the timing generator
//   i_mouse_x/y   new cursor position
//   i_pos_valid   one-cycle strobe qualifying i_mouse_x/y
//   o_cur_x/y     committed cursor position used by the pixel compare
module cursor_pos_buffer
    import mouse_cursor_overlay_pkg::*;
#(
    parameter int X_W             = 10,
    parameter int Y_W             = 10,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter bit SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_vsync,
    input  logic [X_W-1:0] i_mouse_x,
    input  logic [Y_W-1:0] i_mouse_y,
    input  logic           i_pos_valid,
    output logic [X_W-1:0] o_cur_x,
    output logic [Y_W-1:0] o_cur_y
);

    // The idle sync level equals the active-low flag (1 when active-low).
    localparam logic SYNC_IDLE   = SYNC_ACTIVE_LOW;
    localparam logic SYNC_ACTIVE = ~SYNC_ACTIVE_LOW;

    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

    logic           r_vsync_d;
    logic [X_W-1:0] r_pend_x;
    logic [Y_W-1:0] r_pend_y;
    logic           r_pending;
    logic [X_W-1:0] r_cur_x;
    logic [Y_W-1:0] r_cur_y;

    logic           w_frame_start;
    logic [X_W-1:0] w_clamp_x;
    logic [Y_W-1:0] w_clamp_y;

    // Frame start is the idle->active transition of vsync.
    assign w_frame_start = (i_vsync == SYNC_ACTIVE) && (r_vsync_d == SYNC_IDLE);

    assign w_clamp_x = (i_mouse_x > X_MAX) ? X_MAX : i_mouse_x;
    assign w_clamp_y = (i_mouse_y > Y_MAX) ? Y_MAX : i_mouse_y;

    // A strobe landing on the frame-start cycle still lets the older pending
    // value commit; the new value then waits for the following frame, so the
    // strobe branch must win over the pending clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= SYNC_IDLE;
            r_pend_x  <= '0;
            r_pend_y  <= '0;
            r_pending <= 1'b0;
            r_cur_x   <= '0;
            r_cur_y   <= '0;
        end else begin
            r_vsync_d <= i_vsync;
            if (w_frame_start && r_pending) begin
                r_cur_x <= r_pend_x;
                r_cur_y <= r_pend_y;
            end
            if (i_pos_valid) begin
                r_pend_x  <= w_clamp_x;
                r_pend_y  <= w_clamp_y;
                r_pending <= 1'b1;
            end else if (w_frame_start) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_cur_x = r_cur_x;
    assign o_cur_y = r_cur_y;

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Mouse cursor overlay pipeline stage.
// Compares each pixel coordinate with the committed cursor position, drives
// the row index into an external combinational cursor-bitmap ROM, and uses
// the returned row mask to paint the cursor colour over the video stream.
// Every output is delayed by exactly two clocks.
//
// Ports:
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   pixel_x, pixel_y        current pixel coordinate
//   video_on_in             pixel lies in the visible area
//   hsync_in, vsync_in      sync inputs
//   rgb_in                  background colour
//   mouse_x, mouse_y        new cursor position, qualified by pos_valid
//   pos_valid               one-cycle position strobe
//   cursor_en               overlay enable
//   line_number             registered row index to the bitmap ROM
//   line_code               ROM row mask for line_number (bit k = column k)
//   rgb_out                 composited colour
//   video_on_out            delayed video_on
//   hsync_out, vsync_out    delayed syncs
module mouse_cursor_overlay
    import mouse_cursor_overlay_pkg::*;
#(
    parameter int                 X_W             = 10,
    parameter int                 Y_W             = 10,
    parameter int                 RGB_W           = PIX_RGB_W,
    parameter int                 H_ACTIVE        = 640,
    parameter int                 V_ACTIVE        = 480,
    parameter int                 CURSOR_W        = CURSOR_W_DEF,
    parameter int                 CURSOR_H        = CURSOR_H_DEF,
    parameter logic [RGB_W-1:0]   CURSOR_COLOR    = 12'hFFF,
    parameter bit                 SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [X_W-1:0]      pixel_x,
    input  logic [Y_W-1:0]      pixel_y,
    input  logic                video_on_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic [RGB_W-1:0]    rgb_in,
    input  logic [X_W-1:0]      mouse_x,
    input  logic [Y_W-1:0]      mouse_y,
    input  logic                pos_valid,
    input  logic                cursor_en,
    output logic [LINE_W-1:0]   line_number,
    input  logic [CURSOR_W-1:0] line_code,
    output logic [RGB_W-1:0]    rgb_out,
    output logic                video_on_out,
    output logic                hsync_out,
    output logic                vsync_out
);

    localparam int   DX_W      = $clog2(CURSOR_W);
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    localparam pixel_t PIX_RESET = '{rgb: '0, video_on: 1'b0,
                                     hsync: SYNC_IDLE, vsync: SYNC_IDLE};

    logic [X_W-1:0]    w_cur_x;
    logic [Y_W-1:0]    w_cur_y;
    logic [X_W-1:0]    w_dx;
    logic [Y_W-1:0]    w_dy;
    logic              w_hit;
    pixel_t            w_pix_in;

    logic [DX_W-1:0]   r_s1_dx;
    logic              r_s1_hit;
    logic [LINE_W-1:0] r_line_number;
    pixel_t            r_s1_pix;
    pixel_t            r_s2_pix;

    cursor_pos_buffer #(
        .X_W             (X_W),
        .Y_W             (Y_W),
        .H_ACTIVE        (H_ACTIVE),
        .V_ACTIVE        (V_ACTIVE),
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_pos_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vsync     (vsync_in),
        .i_mouse_x   (mouse_x),
        .i_mouse_y   (mouse_y),
        .i_pos_valid (pos_valid),
        .o_cur_x     (w_cur_x),
        .o_cur_y     (w_cur_y)
    );

    // Unsigned offsets; the >= terms reject pixels left of / above the
    // cursor so a wrapped-around difference never counts as a hit.
    assign w_dx  = pixel_x - w_cur_x;
    assign w_dy  = pixel_y - w_cur_y;
    assign w_hit = (pixel_x >= w_cur_x) && (w_dx < X_W'(CURSOR_W)) &&
                   (pixel_y >= w_cur_y) && (w_dy < Y_W'(CURSOR_H));

    assign w_pix_in = '{rgb: rgb_in, video_on: video_on_in,
                        hsync: hsync_in, vsync: vsync_in};

    // Stage 1: the ROM row index depends on geometry only, while the overlay
    // decision also folds in the enable and the visible-area flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_dx       <= '0;
            r_s1_hit      <= 1'b0;
            r_line_number <= NO_LINE;
            r_s1_pix      <= PIX_RESET;
        end else begin
            r_s1_dx       <= w_dx[DX_W-1:0];
            r_s1_hit      <= w_hit & cursor_en & video_on_in;
            r_line_number <= w_hit ? w_dy[LINE_W-1:0] : NO_LINE;
            r_s1_pix      <= w_pix_in;
        end
    end

    // Stage 2: the ROM answers combinationally for r_line_number, so its
    // mask is sampled here alongside the matching stage-1 pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_pix <= PIX_RESET;
        end else begin
            r_s2_pix          <= r_s1_pix;
            r_s2_pix.rgb      <= (r_s1_hit && line_code[r_s1_dx]) ? CURSOR_COLOR
                                                                 : r_s1_pix.rgb;
        end
    end

    assign line_number  = r_line_number;
    assign rgb_out      = r_s2_pix.rgb;
    assign video_on_out = r_s2_pix.video_on;
    assign hsync_out    = r_s2_pix.hsync;
    assign vsync_out    = r_s2_pix.vsync;

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// Directed testbench for mouse_cursor_overlay.
// A small behavioural cursor ROM answers line_number combinationally:
// row 0 is 8'h01 (only column 0 lit), every other row is 8'hFF.
module tb_mouse_cursor_overlay;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] rgb_in;
    logic [9:0]  mouse_x;
    logic [9:0]  mouse_y;
    logic        pos_valid;
    logic        cursor_en;
    logic [4:0]  line_number;
    logic [7:0]  line_code;
    logic [11:0] rgb_out;
    logic        video_on_out;
    logic        hsync_out;
    logic        vsync_out;

    int nChecks = 0;
    int nFails  = 0;

    mouse_cursor_overlay dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .video_on_in  (video_on_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .rgb_in       (rgb_in),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .pos_valid    (pos_valid),
        .cursor_en    (cursor_en),
        .line_number  (line_number),
        .line_code    (line_code),
        .rgb_out      (rgb_out),
        .video_on_out (video_on_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out)
    );

    // 100 MHz-style free-running pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external cursor bitmap ROM
    function automatic logic [7:0] romRow(input logic [4:0] row);
        return (row == 5'd0) ? 8'h01 : 8'hFF;
    endfunction

    assign line_code = romRow(line_number);

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel to the stage
    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                                 input logic vid, input logic hs,
                                 input logic [11:0] rgb);
        pixel_x     = x;
        pixel_y     = y;
        video_on_in = vid;
        hsync_in    = hs;
        rgb_in      = rgb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle position strobe
    task automatic strobePos(input logic [9:0] x, input logic [9:0] y);
        mouse_x   = x;
        mouse_y   = y;
        pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
    endtask

    // Blanked vsync pulse; optionally strobes a position on the frame-start cycle
    task automatic frameEdge(input bit withPos, input logic [9:0] x, input logic [9:0] y);
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 12'h000);
        vsync_in = 1'b0;
        if (withPos) begin
            mouse_x   = x;
            mouse_y   = y;
            pos_valid = 1'b1;
        end
        tick();
        pos_valid = 1'b0;
        checkOutput("vsync_out_before", {31'd0, vsync_out}, 32'd1);
        tick();
        checkOutput("vsync_out_after2", {31'd0, vsync_out}, 32'd0);
        vsync_in = 1'b1;
        tick();
        tick();
    endtask

    // Push one pixel through and check the composited colour two cycles later
    task automatic pixelCheck(input string tag, input logic [9:0] x, input logic [9:0] y,
                              input logic vid, input logic [11:0] rgb,
                              input logic [11:0] expRgb);
        applyStimulus(x, y, vid, 1'b1, rgb);
        tick();
        tick();
        checkOutput(tag, {20'd0, rgb_out}, {20'd0, expRgb});
    endtask

    initial begin
        rst_n     = 1'b0;
        pos_valid = 1'b0;
        mouse_x   = '0;
        mouse_y   = '0;
        cursor_en = 1'b1;
        vsync_in  = 1'b1;
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 12'h000);
        tick();
        tick();

        checkOutput("reset_rgb",   {20'd0, rgb_out},      32'h0);
        checkOutput("reset_video", {31'd0, video_on_out}, 32'd0);
        checkOutput("reset_hsync", {31'd0, hsync_out},    32'd1);
        checkOutput("reset_vsync", {31'd0, vsync_out},    32'd1);
        checkOutput("reset_line",  {27'd0, line_number},  32'd31);

        rst_n = 1'b1;
        tick();
        tick();

        // Commit (100,50) and check the hot-spot pixel with exact latency
        strobePos(10'd100, 10'd50);
        frameEdge(1'b0, 10'd0, 10'd0);
        applyStimulus(10'd100, 10'd50, 1'b1, 1'b1, 12'h123);
        tick();
        checkOutput("t1_line0",      {27'd0, line_number}, 32'd0);
        checkOutput("t1_rgb_lat1",   {20'd0, rgb_out},     32'h000);
        tick();
        checkOutput("t1_rgb_lat2",   {20'd0, rgb_out},     32'hFFF);
        checkOutput("t1_video",      {31'd0, video_on_out}, 32'd1);

        // (101,50): row 0 mask has bit1 clear; hsync latency on the same pixel
        applyStimulus(10'd101, 10'd50, 1'b1, 1'b0, 12'h123);
        tick();
        checkOutput("t1_hsync_lat1", {31'd0, hsync_out}, 32'd1);
        tick();
        checkOutput("t1_hsync_lat2", {31'd0, hsync_out}, 32'd0);
        checkOutput("t1_pass",       {20'd0, rgb_out},   32'h123);

        // Bottom-right corner of the cursor box and one column past it
        applyStimulus(10'd107, 10'd57, 1'b1, 1'b1, 12'h321);
        tick();
        checkOutput("t2_line7", {27'd0, line_number}, 32'd7);
        tick();
        checkOutput("t2_rgb",   {20'd0, rgb_out},     32'hFFF);
        applyStimulus(10'd108, 10'd57, 1'b1, 1'b1, 12'h321);
        tick();
        checkOutput("t2_line_miss", {27'd0, line_number}, 32'd31);
        tick();
        checkOutput("t2_rgb_miss",  {20'd0, rgb_out},     32'h321);
        pixelCheck("t2_left_miss", 10'd99, 10'd50, 1'b1, 12'h222, 12'h222);
        pixelCheck("t2_below_miss", 10'd100, 10'd61, 1'b1, 12'h223, 12'h223);

        // Mid-frame update waits for the next frame
        strobePos(10'd200, 10'd200);
        pixelCheck("t3_before", 10'd200, 10'd200, 1'b1, 12'h456, 12'h456);
        frameEdge(1'b0, 10'd0, 10'd0);
        pixelCheck("t3_after",  10'd200, 10'd200, 1'b1, 12'h456, 12'hFFF);

        // Strobe coinciding with frame start
        strobePos(10'd10, 10'd10);
        frameEdge(1'b1, 10'd20, 10'd20);
        pixelCheck("t4_old_hit",  10'd10, 10'd10, 1'b1, 12'h0A0, 12'hFFF);
        pixelCheck("t4_new_miss", 10'd20, 10'd20, 1'b1, 12'h0B0, 12'h0B0);
        frameEdge(1'b0, 10'd0, 10'd0);
        pixelCheck("t4_new_hit",  10'd20, 10'd20, 1'b1, 12'h0B0, 12'hFFF);
        pixelCheck("t4_old_miss", 10'd10, 10'd10, 1'b1, 12'h0A0, 12'h0A0);

        // Clamp to (639,479) and clipping of blanked pixels
        strobePos(10'd700, 10'd600);
        frameEdge(1'b0, 10'd0, 10'd0);
        pixelCheck("t5_corner",    10'd639, 10'd479, 1'b1, 12'h777, 12'hFFF);
        pixelCheck("t5_left_miss", 10'd638, 10'd479, 1'b1, 12'h777, 12'h777);
        applyStimulus(10'd639, 10'd480, 1'b0, 1'b1, 12'h000);
        tick();
        checkOutput("t5_clip_line", {27'd0, line_number}, 32'd1);
        tick();
        checkOutput("t5_clip_rgb",  {20'd0, rgb_out},     32'h000);
        checkOutput("t5_clip_vid",  {31'd0, video_on_out}, 32'd0);
        cursor_en = 1'b0;
        pixelCheck("t5_disabled",  10'd639, 10'd479, 1'b1, 12'h778, 12'h778);
        cursor_en = 1'b1;

        // Asynchronous reset in the middle of an overlaid pixel
        strobePos(10'd300, 10'd300);
        pixelCheck("t6_pre_reset", 10'd639, 10'd479, 1'b1, 12'h999, 12'hFFF);
        applyStimulus(10'd0, 10'd0, 1'b1, 1'b0, 12'h456);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_rgb",   {20'd0, rgb_out},     32'h000);
        checkOutput("t6_rst_hsync", {31'd0, hsync_out},   32'd1);
        checkOutput("t6_rst_vsync", {31'd0, vsync_out},   32'd1);
        checkOutput("t6_rst_line",  {27'd0, line_number}, 32'd31);
        #1;
        rst_n = 1'b1;
        tick();
        checkOutput("t6_rel_rgb1",  {20'd0, rgb_out},   32'h000);
        checkOutput("t6_rel_hs1",   {31'd0, hsync_out}, 32'd1);
        checkOutput("t6_rel_line",  {27'd0, line_number}, 32'd0);
        tick();
        checkOutput("t6_rel_rgb2",  {20'd0, rgb_out},   32'hFFF);
        checkOutput("t6_rel_hs2",   {31'd0, hsync_out}, 32'd0);
        frameEdge(1'b0, 10'd0, 10'd0);
        pixelCheck("t6_drop_hit",  10'd0,   10'd0,   1'b1, 12'h456, 12'hFFF);
        pixelCheck("t6_drop_miss", 10'd300, 10'd300, 1'b1, 12'h654, 12'h654);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mouse_cursor_overlay.md
Name: mouse_cursor_overlay

Overview:
- Pixel-pipeline stage that sits directly upstream of the combinational cursor-bitmap ROM.
- Compares each incoming pixel coordinate against the latched mouse position and drives the ROM row index (`line_number`).
- Samples the returned 8-bit row mask and overlays the cursor colour onto the video stream.
- Mouse position updates are double-buffered and committed only at frame start, so the cursor never tears.

Parameters:
- X_W, 10, width of pixel_x / mouse_x.
- Y_W, 10, width of pixel_y / mouse_y.
- RGB_W, 12, pixel colour width.
- H_ACTIVE, 640, visible columns; mouse_x clamp limit.
- V_ACTIVE, 480, visible rows; mouse_y clamp limit.
- CURSOR_W, 8, cursor bitmap width (bits of line_code).
- CURSOR_H, 11, cursor bitmap rows (0..10).
- CURSOR_COLOR, 12'hFFF, overlay colour.
- SYNC_ACTIVE_LOW, 1, polarity of hsync/vsync (1 = active-low).

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous active-low reset.
- pixel_x  input  X_W  current pixel column from timing generator.
- pixel_y  input  Y_W  current pixel row.
- video_on_in  input  1  pixel is in the visible area.
- hsync_in  input  1  horizontal sync.
- vsync_in  input  1  vertical sync.
- rgb_in  input  RGB_W  background pixel colour.
- mouse_x  input  X_W  new cursor column.
- mouse_y  input  Y_W  new cursor row.
- pos_valid  input  1  one-cycle strobe qualifying mouse_x/mouse_y.
- cursor_en  input  1  overlay enable.
- line_number  output  5  row index to bitmap ROM (registered).
- line_code  input  8  ROM row mask; bit k = column offset k; valid the same cycle as line_number.
- rgb_out  output  RGB_W  composited pixel.
- video_on_out  output  1  delayed video_on.
- hsync_out  output  1  delayed hsync.
- vsync_out  output  1  delayed vsync.

Behaviour:
- Reset (async assert, sync release):
  - rgb_out=0, video_on_out=0, line_number=5'd31.
  - hsync_out/vsync_out = inactive level (1 if SYNC_ACTIVE_LOW, else 0).
  - cur_x=cur_y=0, pend_x=pend_y=0, pending=0, vsync_d=inactive.
  - Reset mid-frame flushes the pipeline. Outputs stay at reset values until 2 cycles after release. A pending position is discarded.
- Position capture:
  - On pos_valid, pend_x=min(mouse_x,H_ACTIVE-1), pend_y=min(mouse_y,V_ACTIVE-1), pending=1.
  - Later strobes overwrite the pending value (last one wins).
- Frame commit:
  - frame_start = vsync_in transitioning inactive->active (edge against registered vsync_d).
  - On frame_start with pending=1: cur_x/cur_y <= pend_x/pend_y, pending <= 0.
  - If pos_valid coincides with frame_start: the old pending value commits, the new value is captured, and pending stays 1.
- Stage 1 (register at edge t+1 for inputs at t):
  - dx=pixel_x-cur_x, dy=pixel_y-cur_y.
  - hit = pixel_x>=cur_x && dx<CURSOR_W && pixel_y>=cur_y && dy<CURSOR_H.
  - Registered: s1_dx=dx[2:0], s1_hit=hit & cursor_en & video_on_in, line_number = hit ? dy[4:0] : 5'd31.
  - rgb, video_on, hsync and vsync are also registered.
  - Comparisons are unsigned. Pixels left of or above the cursor are misses; no wrap-around.
- Stage 2 (edge t+2):
  - rgb_out = (s1_hit && line_code[s1_dx]) ? CURSOR_COLOR : s1_rgb.
  - video_on/hsync/vsync are delayed one more stage.
- Latency: fixed 2 cycles for every output, with identical delay on all outputs.
- Clipping: a cursor near the right/bottom edge extends past the active area. Those pixels have video_on_in=0 and are never overlaid.
- Blanking: when video_on=0, rgb_out passes rgb_in unchanged (the timing generator supplies 0).

Decomposition:
- Shared package holds:
  - SYNC_ACTIVE_LOW default.
  - CURSOR_W/CURSOR_H constants.
  - line-number width (5).
  - NO_LINE=5'd31.
  - pixel struct {rgb, video_on, hsync, vsync}.
- One natural sub-module: cursor_pos_buffer (pending/commit registers, clamp, frame_start edge detect).
- The pipeline stays in the top module. The bitmap ROM is instantiated by the parent, not inside this block.

Test Plan:
- Reset release, then pos_valid with (100,50), then a vsync edge. Pixel (100,50) with ROM row0=8'h01 -> rgb_out=12'hFFF exactly 2 cycles later. Pixel (101,50) -> rgb_in passes through.
- Pixel (107,57) with line_code=8'hFF -> overlay; line_number=7 observed at cycle+1. Pixel (108,57) -> line_number=31, no overlay.
- pos_valid (200,200) mid-frame -> pixel (200,200) not overlaid until after the next vsync edge. Then it is overlaid.
- pos_valid coincident with the vsync edge (old pending 10,10; new 20,20) -> cur=(10,10) this frame, pending still set, cur=(20,20) next frame.
- mouse_x=700, mouse_y=600 -> cur clamps to (639,479). Only pixel (639,479) can be overlaid. Pixels with video_on_in=0 are never overlaid.
- Assert rst_n low mid-line with cursor_en=1 -> outputs are immediately rgb_out=0, hsync_out=vsync_out=1, line_number=31. Pending is dropped. The first valid output appears 2 cycles after release.
